// File: rtl/eth_tx_arbiter.sv
// eth_tx_arbiter: frame-granular 2:1 AXI-Stream TX arbiter with a stall-timeout abort path.
// Define ETH_TX_ARB_FIXED_PRIO_EN for fixed priority (s0 wins ties) instead of round-robin.
module eth_tx_arbiter #(
  parameter int unsigned STALL_TIMEOUT = 1024
) (
  input  logic       clock125,
  input  logic       reset,
  input  logic [7:0] s0_axis_tdata,
  input  logic       s0_axis_tvalid,
  output logic       s0_axis_tready,
  input  logic       s0_axis_tlast,
  input  logic       s0_axis_tuser,
  input  logic [7:0] s1_axis_tdata,
  input  logic       s1_axis_tvalid,
  output logic       s1_axis_tready,
  input  logic       s1_axis_tlast,
  input  logic       s1_axis_tuser,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       m_axis_tlast,
  output logic       m_axis_tuser,
  output logic [1:0] grant,
  output logic       abort
);

  // Handshake: a beat moves across a port in the cycle where its tvalid and tready are
  // both high; the producer holds tvalid and payload stable until that cycle.

  typedef enum logic [1:0] {IDLE, SEND, ABORT_OUT, DROP} state_t;

  localparam logic [15:0] TIMEOUT_M1 = 16'(STALL_TIMEOUT - 1);

  state_t      state, state_nxt;
  logic        sel, sel_nxt;
  logic        pick;
  logic [15:0] stall_cnt, stall_nxt;
  logic        abort_nxt;
  logic        sel_tready;

  logic [7:0]  sel_tdata;
  logic        sel_tvalid;
  logic        sel_tlast;
  logic        sel_tuser;

  assign sel_tdata  = sel ? s1_axis_tdata  : s0_axis_tdata;
  assign sel_tvalid = sel ? s1_axis_tvalid : s0_axis_tvalid;
  assign sel_tlast  = sel ? s1_axis_tlast  : s0_axis_tlast;
  assign sel_tuser  = sel ? s1_axis_tuser  : s0_axis_tuser;

  assign s0_axis_tready = sel_tready & ~sel;
  assign s1_axis_tready = sel_tready &  sel;

  assign grant = (state == IDLE) ? 2'b00 : (sel ? 2'b10 : 2'b01);

`ifdef ETH_TX_ARB_FIXED_PRIO_EN
  assign pick = ~s0_axis_tvalid;
`else
  logic last_grant;
  logic frame_done;

  // Ties go to whichever requester did not finish the previous frame.
  assign pick = (s0_axis_tvalid && s1_axis_tvalid) ? ~last_grant : ~s0_axis_tvalid;

  assign frame_done = sel_tvalid && sel_tlast &&
                      (((state == SEND) && m_axis_tready) || (state == DROP));

  always_ff @(posedge clock125) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (frame_done) begin
      last_grant <= sel;
    end
  end
`endif

  always_comb begin
    state_nxt     = state;
    sel_nxt       = sel;
    stall_nxt     = stall_cnt;
    abort_nxt     = 1'b0;
    sel_tready    = 1'b0;
    m_axis_tdata  = 8'h00;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = 1'b0;
    case (state)
      IDLE: begin
        if (s0_axis_tvalid || s1_axis_tvalid) begin
          sel_nxt   = pick;
          stall_nxt = 16'd0;
          state_nxt = SEND;
        end
      end
      SEND: begin
        m_axis_tdata  = sel_tdata;
        m_axis_tvalid = sel_tvalid;
        m_axis_tlast  = sel_tlast;
        m_axis_tuser  = sel_tuser;
        sel_tready    = m_axis_tready;
        if (sel_tvalid) begin
          if (m_axis_tready) begin
            stall_nxt = 16'd0;
            if (sel_tlast) state_nxt = IDLE;
          end
        end else begin
          // Only a silent source counts toward the timeout; MAC backpressure never does.
          stall_nxt = stall_cnt + 16'd1;
          if (stall_cnt == TIMEOUT_M1) state_nxt = ABORT_OUT;
        end
      end
      ABORT_OUT: begin
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = 1'b1;
        m_axis_tuser  = 1'b1;
        if (m_axis_tready) begin
          abort_nxt = 1'b1;
          state_nxt = DROP;
        end
      end
      DROP: begin
        sel_tready = 1'b1;
        if (sel_tvalid && sel_tlast) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock125) begin
    if (reset) begin
      state     <= IDLE;
      sel       <= 1'b0;
      stall_cnt <= 16'd0;
      abort     <= 1'b0;
    end else begin
      state     <= state_nxt;
      sel       <= sel_nxt;
      stall_cnt <= stall_nxt;
      abort     <= abort_nxt;
    end
  end

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Self-checking bench for eth_tx_arbiter: per-source frame drivers, output scoreboard, summary.
`timescale 1ns/1ps
module tb_eth_tx_arbiter;

  localparam int         STALL  = 16;
  localparam logic [7:0] GAP_DC = 8'hFF;
`ifdef ETH_TX_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic       clock125;
  logic       reset;
  logic [7:0] s0_axis_tdata, s1_axis_tdata, m_axis_tdata;
  logic       s0_axis_tvalid, s0_axis_tready, s0_axis_tlast, s0_axis_tuser;
  logic       s1_axis_tvalid, s1_axis_tready, s1_axis_tlast, s1_axis_tuser;
  logic       m_axis_tvalid, m_axis_tready, m_axis_tlast, m_axis_tuser;
  logic [1:0] grant;
  logic       abort;

  int checks = 0;
  int errors = 0;

  // Expected output beat: {gap[7:0], src, tuser, tlast, tdata[7:0]}
  logic [18:0] exp_q[$];
  logic [8:0]  src0_q[$];
  logic [8:0]  src1_q[$];
  logic [18:0] e_mon;

  int   s0_sent = 0;
  int   s1_sent = 0;
  int   s0_stall_at = -1;
  logic s0_acc = 1'b0;
  logic s1_acc = 1'b0;
  int   out_cnt = 0;
  int   abort_cnt = 0;
  int   gap = 0;
  logic model_lg = 1'b1;
  bit   rnd_done = 1'b0;
  int   base;

  eth_tx_arbiter #(.STALL_TIMEOUT(STALL)) dut (
    .clock125       (clock125),
    .reset          (reset),
    .s0_axis_tdata  (s0_axis_tdata),
    .s0_axis_tvalid (s0_axis_tvalid),
    .s0_axis_tready (s0_axis_tready),
    .s0_axis_tlast  (s0_axis_tlast),
    .s0_axis_tuser  (s0_axis_tuser),
    .s1_axis_tdata  (s1_axis_tdata),
    .s1_axis_tvalid (s1_axis_tvalid),
    .s1_axis_tready (s1_axis_tready),
    .s1_axis_tlast  (s1_axis_tlast),
    .s1_axis_tuser  (s1_axis_tuser),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .m_axis_tlast   (m_axis_tlast),
    .m_axis_tuser   (m_axis_tuser),
    .grant          (grant),
    .abort          (abort)
  );

  // Clock and reset
  initial begin
    clock125 = 1'b0;
    forever #4 clock125 = ~clock125;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_mvalid"}, m_axis_tvalid, 1'b0);
    check({tag, "_mpayload"}, {m_axis_tlast, m_axis_tuser, m_axis_tdata}, 10'd0);
    check({tag, "_sready"}, {s0_axis_tready, s1_axis_tready}, 2'b00);
    check({tag, "_grant"}, grant, 2'b00);
    check({tag, "_abort"}, abort, 1'b0);
  endtask

  // Source drivers: present the queue head, advance after an accepted beat.
  initial begin
    s0_axis_tvalid = 1'b0; s0_axis_tdata = 8'h00; s0_axis_tlast = 1'b0; s0_axis_tuser = 1'b0;
    forever begin
      @(posedge clock125); #1;
      if (reset) begin
        src0_q.delete();
      end else if (s0_acc && src0_q.size() != 0) begin
        void'(src0_q.pop_front());
        s0_sent++;
      end
      if (!reset && src0_q.size() != 0 && s0_sent != s0_stall_at) begin
        s0_axis_tvalid = 1'b1;
        {s0_axis_tlast, s0_axis_tdata} = src0_q[0];
      end else begin
        s0_axis_tvalid = 1'b0; s0_axis_tdata = 8'h00; s0_axis_tlast = 1'b0;
      end
    end
  end

  initial begin
    s1_axis_tvalid = 1'b0; s1_axis_tdata = 8'h00; s1_axis_tlast = 1'b0; s1_axis_tuser = 1'b0;
    forever begin
      @(posedge clock125); #1;
      if (reset) begin
        src1_q.delete();
      end else if (s1_acc && src1_q.size() != 0) begin
        void'(src1_q.pop_front());
        s1_sent++;
      end
      if (!reset && src1_q.size() != 0) begin
        s1_axis_tvalid = 1'b1;
        {s1_axis_tlast, s1_axis_tdata} = src1_q[0];
      end else begin
        s1_axis_tvalid = 1'b0; s1_axis_tdata = 8'h00; s1_axis_tlast = 1'b0;
      end
    end
  end

  // Output monitor and scoreboard
  initial begin
    forever begin
      @(negedge clock125);
      if (reset) begin
        s0_acc = 1'b0; s1_acc = 1'b0; gap = 0;
      end else begin
        s0_acc = s0_axis_tvalid & s0_axis_tready;
        s1_acc = s1_axis_tvalid & s1_axis_tready;
        if (abort) abort_cnt++;
        if (m_axis_tvalid && m_axis_tready) begin
          check("exp_avail", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            e_mon = exp_q.pop_front();
            check("beat", {grant, m_axis_tuser, m_axis_tlast, m_axis_tdata},
                  {(e_mon[10] ? 2'b10 : 2'b01), e_mon[9], e_mon[8], e_mon[7:0]});
            if (e_mon[18:11] != GAP_DC) check("gap", gap, e_mon[18:11]);
          end
          out_cnt++;
          gap = 0;
        end else if (!m_axis_tvalid) begin
          gap = (gap >= 255) ? 255 : gap + 1;
        end
      end
    end
  end

  task automatic push_frame(input bit w, input int len, input logic [7:0] first_gap);
    logic [7:0] b;
    logic       last;
    for (int i = 0; i < len; i++) begin
      b    = 8'($urandom_range(0, 255));
      last = (i == len - 1);
      if (w) src1_q.push_back({last, b});
      else   src0_q.push_back({last, b});
      exp_q.push_back({((i == 0) ? first_gap : 8'd0), w, 1'b0, last, b});
    end
  endtask

  // Arbitration model for frames posted back-to-back from the same instant.
  task automatic load_pair(input int n0, input int n1, input int lo, input int hi);
    int r0 = n0;
    int r1 = n1;
    bit w;
    bit first = 1'b1;
    while (r0 > 0 || r1 > 0) begin
      if (r0 > 0 && r1 > 0) w = FIXED ? 1'b0 : ~model_lg;
      else                  w = (r0 == 0);
      push_frame(w, int'($urandom_range(lo, hi)), first ? GAP_DC : 8'd1);
      model_lg = w;
      if (w) r1--; else r0--;
      first = 1'b0;
    end
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clock125);
      n++;
    end
    check(tag, exp_q.size(), 0);
    repeat (3) @(posedge clock125);
  endtask

  task automatic wait_out(input string tag, input int target, input int budget);
    int n = 0;
    while (out_cnt < target && n < budget) begin
      @(posedge clock125);
      n++;
    end
    check(tag, out_cnt >= target, 1'b1);
  endtask

  initial begin
    reset = 1'b1;
    m_axis_tready = 1'b1;
    repeat (3) @(posedge clock125);
    @(negedge clock125);
    check_zero("por");
    @(posedge clock125); #1 reset = 1'b0;

    // Both requesters post 64-byte frames continuously
    @(negedge clock125);
    load_pair(2, 2, 64, 64);
    wait_drain("t1_drain", 2000);
    @(negedge clock125);
    check("t1_abort", abort_cnt, 0);
    check("t1_idle", grant, 2'b00);

    // Long MAC backpressure mid-frame must not abort
    base = out_cnt;
    @(negedge clock125);
    load_pair(0, 1, 40, 40);
    wait_out("t2_wait", base + 20, 500);
    @(posedge clock125); #2 m_axis_tready = 1'b0;
    repeat (5000) @(posedge clock125);
    @(negedge clock125);
    check("t2_hold_valid", m_axis_tvalid, 1'b1);
    check("t2_hold_grant", grant, 2'b10);
    @(posedge clock125); #2 m_axis_tready = 1'b1;
    wait_drain("t2_drain", 500);
    check("t2_abort", abort_cnt, 0);

    // s0 goes silent after 10 of 60 bytes
    @(negedge clock125);
    s0_stall_at = s0_sent + 10;
    for (int i = 0; i < 60; i++) begin
      logic [7:0] b;
      b = 8'($urandom_range(0, 255));
      src0_q.push_back({(i == 59), b});
      if (i < 10) exp_q.push_back({((i == 0) ? GAP_DC : 8'd0), 1'b0, 1'b0, 1'b0, b});
    end
    exp_q.push_back({8'(STALL), 1'b0, 1'b1, 1'b1, 8'h00});
    model_lg = 1'b0;
    begin
      int n = 0;
      while (abort_cnt == 0 && n < 500) begin
        @(posedge clock125);
        n++;
      end
    end
    s0_stall_at = -1;
    begin
      int n = 0;
      while (src0_q.size() != 0 && n < 500) begin
        @(posedge clock125);
        n++;
      end
    end
    check("t3_dropped", src0_q.size(), 0);
    wait_drain("t3_drain", 200);
    @(negedge clock125);
    check("t3_abort_cnt", abort_cnt, 1);
    check("t3_idle", grant, 2'b00);

    // Single-beat frame
    @(negedge clock125);
    load_pair(0, 1, 1, 1);
    wait_drain("t4_drain", 100);
    @(negedge clock125);
    check("t4_idle", grant, 2'b00);

    // Random MAC backpressure over short frames
    rnd_done = 1'b0;
    fork
      begin
        while (!rnd_done) begin
          @(posedge clock125); #2;
          m_axis_tready = ($urandom_range(0, 3) != 0);
        end
      end
    join_none
    @(negedge clock125);
    load_pair(2, 1, 1, 8);
    wait_drain("t5_drain", 3000);
    rnd_done = 1'b1;
    repeat (2) @(posedge clock125);
    #3 m_axis_tready = 1'b1;

    // Reset at byte 30 of an s1 frame
    base = out_cnt;
    @(negedge clock125);
    load_pair(0, 1, 60, 60);
    wait_out("t6_wait", base + 30, 500);
    #1 reset = 1'b1;
    @(posedge clock125);
    @(negedge clock125);
    check_zero("mid_rst");
    exp_q.delete();
    repeat (2) @(posedge clock125);
    #1 reset = 1'b0;
    model_lg = 1'b1;
    @(negedge clock125);
    load_pair(1, 1, 4, 4);
    wait_drain("t6_drain", 200);
    @(negedge clock125);
    check("t6_abort", abort_cnt, 1);
    check("t6_idle", grant, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/eth_tx_arbiter.md
ETH_TX_ARBITER -- requirements
Module: eth_tx_arbiter

Interface
REQ-001 Parameter STALL_TIMEOUT, default 1024: max consecutive idle cycles inside a granted frame before abort; legal range 2..65535.
REQ-002 clock125  input  1  sole clock, 125 MHz; all ports synchronous to it.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 s0_axis_tdata/tvalid/tready/tlast/tuser  in/in/out/in/in  8/1/1/1/1  requester 0 TX frame stream.
REQ-005 s1_axis_tdata/tvalid/tready/tlast/tuser  in/in/out/in/in  8/1/1/1/1  requester 1 TX frame stream.
REQ-006 m_axis_tdata/tvalid/tready/tlast/tuser  out/out/in/out/out  8/1/1/1/1  merged stream to MAC TX AXIS.
REQ-007 grant  output  2  one-hot current owner, bit0 = s0, bit1 = s1; 0 when idle.
REQ-008 abort  output  1  one-cycle pulse per timeout-aborted frame.

Function
REQ-009 Arbitration SHALL be frame-granular; a granted frame SHALL never be interleaved with the other requester.
REQ-010 States: IDLE, SEND, ABORT_OUT, DROP; single registered state variable plus registered select (sel) and last_grant.
REQ-011 IDLE: m_axis_tvalid=0, both s*_tready=0; if any s*_tvalid=1, register sel per REQ-018 and enter SEND next cycle (one-cycle arbitration latency).
REQ-012 SEND: m_axis_tdata/tvalid/tlast/tuser combinationally equal s[sel]; s[sel]_tready = m_axis_tready; other tready=0; zero added latency.
REQ-013 SEND: beat with tvalid&tready&tlast SHALL return to IDLE next cycle and set last_grant=sel.
REQ-014 Stall counter, 16 bits, cleared on entry to SEND and on every accepted beat; increments only when s[sel]_tvalid=0; m_axis_tready=0 SHALL NOT increment it.
REQ-015 Counter reaching STALL_TIMEOUT SHALL move SEND to ABORT_OUT next cycle.
REQ-016 ABORT_OUT: m_axis_tvalid=1, tdata=0x00, tlast=1, tuser=1, both s*_tready=0; held until m_axis_tready=1; then abort pulses and state enters DROP.
REQ-017 DROP: s[sel]_tready=1, m_axis_tvalid=0; beats discarded until a tlast beat is accepted, then IDLE with last_grant=sel.
REQ-018 Round-robin (default): single requester wins; both valid -> requester != last_grant wins.
REQ-019 grant SHALL equal one-hot(sel) in SEND, ABORT_OUT, DROP; 0 in IDLE.
REQ-020 A requester asserting tvalid in the same cycle the other's tlast is accepted SHALL be considered in the following IDLE cycle only.
REQ-021 Single-beat frame (tlast on first beat) SHALL be legal: SEND lasts one transfer cycle.

Reset
REQ-022 On reset: state=IDLE, sel=0, last_grant=1 (s0 wins first tie), stall counter=0.
REQ-023 Outputs during/after reset: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tuser=0, m_axis_tdata=0, s*_tready=0, grant=0, abort=0.
REQ-024 Reset mid-frame SHALL abandon the frame without emitting tlast; MAC is reset by the same signal.

Configuration
REQ-025 Macro ETH_TX_ARB_FIXED_PRIO_EN defined: REQ-018 replaced by fixed priority, s0 always wins ties; last_grant unused.
REQ-026 Macro undefined: round-robin per REQ-018; ports identical in both builds.

Verification
REQ-027 Both requesters post 64-byte frames continuously, m_axis_tready=1 -> output alternates s0,s1,s0 frames, one idle cycle between, grant toggles 01/10.
REQ-028 Same with ETH_TX_ARB_FIXED_PRIO_EN -> only s0 frames output while s0 keeps tvalid; s1 tready stays 0.
REQ-029 s0 stops tvalid after 10 of 60 bytes, STALL_TIMEOUT=16 -> after 16 idle cycles one beat tdata=0x00,tlast=1,tuser=1; abort pulses once; remaining 50 s0 bytes dropped; then IDLE.
REQ-030 m_axis_tready held low 5000 cycles mid-frame, source valid -> no abort; frame completes intact.
REQ-031 reset asserted at byte 30 of a s1 frame -> next cycle all outputs 0, grant=0; after release s0 wins first tie.
